multicycle_control_unit: RTL and testbench

- Next-generation RV32I control unit: sequential FSM sequencing FETCH/DECODE/EXEC/MEM/WB over a shared datapath.
- Decodes the instruction register into the existing control-signal set (ExtOp, ALUASrc/ALUBSrc, ALUCtr, MemOp encodings unchanged).
- Adds:
  - instruction/data memory request-valid handshakes;
  - optional M-extension multi-cycle wait;
  - data-bus timeout;
  - illegal-instruction trap.
- Sits between fetch/memory ports and the datapath (regfile, ALU, PC mux).

---
 rtl/rv32_ctrl_pkg.sv | 103 ++++++++++
 rtl/multicycle_control_unit_if.sv | 36 +++
 rtl/rv32_decoder.sv | 155 +++++++++++++++
 rtl/multicycle_control_unit.sv | 147 ++++++++++++++
 tb/tb_multicycle_control_unit.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: opcodes, ALU codes,
// operand/immediate/memory selects, FSM states and the decoded control bundle.
package rv32_ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [4:0] ALU_ADD    = 5'b00000;
  localparam logic [4:0] ALU_SUB    = 5'b00001;
  localparam logic [4:0] ALU_SLL    = 5'b00010;
  localparam logic [4:0] ALU_SLT    = 5'b00011;
  localparam logic [4:0] ALU_SLTU   = 5'b00100;
  localparam logic [4:0] ALU_XOR    = 5'b00101;
  localparam logic [4:0] ALU_SRL    = 5'b00110;
  localparam logic [4:0] ALU_SRA    = 5'b00111;
  localparam logic [4:0] ALU_OR     = 5'b01000;
  localparam logic [4:0] ALU_AND    = 5'b01001;
  localparam logic [4:0] ALU_ADDI   = 5'b01010;
  localparam logic [4:0] ALU_SLTI   = 5'b01011;
  localparam logic [4:0] ALU_SLTIU  = 5'b01100;
  localparam logic [4:0] ALU_XORI   = 5'b01101;
  localparam logic [4:0] ALU_ORI    = 5'b01110;
  localparam logic [4:0] ALU_ANDI   = 5'b01111;
  localparam logic [4:0] ALU_LUI    = 5'b10000;
  localparam logic [4:0] ALU_AUIPC  = 5'b10001;
  localparam logic [4:0] ALU_SLLI   = 5'b10010;
  localparam logic [4:0] ALU_SRLI   = 5'b10011;
  localparam logic [4:0] ALU_BEQ    = 5'b10100;
  localparam logic [4:0] ALU_BNE    = 5'b10101;
  localparam logic [4:0] ALU_BLT    = 5'b10110;
  localparam logic [4:0] ALU_BGE    = 5'b10111;
  localparam logic [4:0] ALU_BLTU   = 5'b11000;
  localparam logic [4:0] ALU_BGEU   = 5'b11001;
  localparam logic [4:0] ALU_SRAI   = 5'b11010;
  localparam logic [4:0] ALU_MULDIV = 5'b11011;

  localparam logic [2:0] EXT_I = 3'b000;
  localparam logic [2:0] EXT_B = 3'b001;
  localparam logic [2:0] EXT_J = 3'b010;
  localparam logic [2:0] EXT_S = 3'b011;
  localparam logic [2:0] EXT_U = 3'b100;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_BU = 3'b001;
  localparam logic [2:0] MEM_H  = 3'b010;
  localparam logic [2:0] MEM_HU = 3'b011;
  localparam logic [2:0] MEM_W  = 3'b100;

  localparam logic       ASRC_RS1  = 1'b0;
  localparam logic       ASRC_PC   = 1'b1;
  localparam logic [1:0] BSRC_RS2  = 2'd0;
  localparam logic [1:0] BSRC_IMM  = 2'd1;
  localparam logic [1:0] BSRC_FOUR = 2'd2;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_REG   = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_MD  = 2'd3;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_MDWAIT = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    K_ALU, K_BRANCH, K_JAL, K_JALR, K_LOAD, K_STORE, K_MULDIV
  } kind_t;

  typedef struct packed {
    kind_t      kind;
    logic [2:0] ext_op;
    logic       alu_a_src;
    logic [1:0] alu_b_src;
    logic [4:0] alu_ctr;
    logic [2:0] mem_op;
    logic [1:0] wb_sel;
    logic       reg_wr;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit bundle: memory/mul-div handshakes inbound, datapath controls outbound.
interface multicycle_control_unit_if #(parameter int XLEN = 32);
  logic            imem_req;
  logic            imem_valid;
  logic [XLEN-1:0] imem_rdata;
  logic            dmem_req;
  logic            dmem_ready;
  logic            branch_cond;
  logic            md_done;
  logic            md_start;
  logic            ir_we;
  logic            pc_we;
  logic [1:0]      pc_sel;
  logic [1:0]      wb_sel;
  logic [2:0]      ExtOp;
  logic            RegWr;
  logic            ALUASrc;
  logic [1:0]      ALUBSrc;
  logic [4:0]      ALUCtr;
  logic            MemWr;
  logic [2:0]      MemOp;
  logic            trap;
  logic [2:0]      state;

  modport master (
    input  imem_valid, imem_rdata, dmem_ready, branch_cond, md_done,
    output imem_req, dmem_req, md_start, ir_we, pc_we, pc_sel, wb_sel, ExtOp,
           RegWr, ALUASrc, ALUBSrc, ALUCtr, MemWr, MemOp, trap, state
  );

  modport slave (
    output imem_valid, imem_rdata, dmem_ready, branch_cond, md_done,
    input  imem_req, dmem_req, md_start, ir_we, pc_we, pc_sel, wb_sel, ExtOp,
           RegWr, ALUASrc, ALUBSrc, ALUCtr, MemWr, MemOp, trap, state
  );
endinterface

// File: rtl/rv32_decoder.sv
// Purely combinational RV32I(+M) instruction decoder producing the control bundle
// and an illegal-instruction flag.
module rv32_decoder
  import rv32_ctrl_pkg::*;
#(
  parameter bit ENABLE_M = 1'b0
) (
  input  logic [31:0] ir,
  output ctrl_t       ctrl,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [6:0] func7;
  logic [2:0] func3;
  logic       rd_nz;
  logic       unused_ir_bits;

  assign opcode         = ir[6:0];
  assign func3          = ir[14:12];
  assign func7          = ir[31:25];
  assign rd_nz          = (ir[11:7] != 5'd0);
  assign unused_ir_bits = ^ir[24:15];

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (opcode)
      OPC_LUI: begin
        ctrl.ext_op    = EXT_U;
        ctrl.alu_b_src = BSRC_IMM;
        ctrl.alu_ctr   = ALU_LUI;
        ctrl.reg_wr    = rd_nz;
      end
      OPC_AUIPC: begin
        ctrl.ext_op    = EXT_U;
        ctrl.alu_a_src = ASRC_PC;
        ctrl.alu_b_src = BSRC_IMM;
        ctrl.alu_ctr   = ALU_AUIPC;
        ctrl.reg_wr    = rd_nz;
      end
      OPC_JAL: begin
        ctrl.kind      = K_JAL;
        ctrl.ext_op    = EXT_J;
        ctrl.alu_a_src = ASRC_PC;
        ctrl.alu_b_src = BSRC_FOUR;
        ctrl.alu_ctr   = ALU_ADD;
        ctrl.wb_sel    = WB_PC4;
        ctrl.reg_wr    = rd_nz;
      end
      OPC_JALR: begin
        ctrl.kind      = K_JALR;
        ctrl.ext_op    = EXT_I;
        ctrl.alu_b_src = BSRC_IMM;
        ctrl.alu_ctr   = ALU_ADD;
        ctrl.wb_sel    = WB_PC4;
        ctrl.reg_wr    = rd_nz;
        illegal        = (func3 != 3'b000);
      end
      OPC_BRANCH: begin
        ctrl.kind   = K_BRANCH;
        ctrl.ext_op = EXT_B;
        case (func3)
          3'b000:  ctrl.alu_ctr = ALU_BEQ;
          3'b001:  ctrl.alu_ctr = ALU_BNE;
          3'b100:  ctrl.alu_ctr = ALU_BLT;
          3'b101:  ctrl.alu_ctr = ALU_BGE;
          3'b110:  ctrl.alu_ctr = ALU_BLTU;
          3'b111:  ctrl.alu_ctr = ALU_BGEU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        ctrl.kind      = K_LOAD;
        ctrl.ext_op    = EXT_I;
        ctrl.alu_b_src = BSRC_IMM;
        ctrl.alu_ctr   = ALU_ADD;
        ctrl.wb_sel    = WB_MEM;
        ctrl.reg_wr    = rd_nz;
        case (func3)
          3'b000:  ctrl.mem_op = MEM_B;
          3'b001:  ctrl.mem_op = MEM_H;
          3'b010:  ctrl.mem_op = MEM_W;
          3'b100:  ctrl.mem_op = MEM_BU;
          3'b101:  ctrl.mem_op = MEM_HU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        ctrl.kind      = K_STORE;
        ctrl.ext_op    = EXT_S;
        ctrl.alu_b_src = BSRC_IMM;
        ctrl.alu_ctr   = ALU_ADD;
        case (func3)
          3'b000:  ctrl.mem_op = MEM_B;
          3'b001:  ctrl.mem_op = MEM_H;
          3'b010:  ctrl.mem_op = MEM_W;
          default: illegal = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        ctrl.ext_op    = EXT_I;
        ctrl.alu_b_src = BSRC_IMM;
        ctrl.reg_wr    = rd_nz;
        case (func3)
          3'b000: ctrl.alu_ctr = ALU_ADDI;
          3'b010: ctrl.alu_ctr = ALU_SLTI;
          3'b011: ctrl.alu_ctr = ALU_SLTIU;
          3'b100: ctrl.alu_ctr = ALU_XORI;
          3'b110: ctrl.alu_ctr = ALU_ORI;
          3'b111: ctrl.alu_ctr = ALU_ANDI;
          3'b001: begin
            ctrl.alu_ctr = ALU_SLLI;
            illegal      = (func7 != F7_BASE);
          end
          default: begin
            // Only shift-right immediates reach here; func7 picks logical vs arithmetic.
            ctrl.alu_ctr = (func7 == F7_ALT) ? ALU_SRAI : ALU_SRLI;
            illegal      = (func7 != F7_BASE) && (func7 != F7_ALT);
          end
        endcase
      end
      OPC_OP: begin
        ctrl.alu_b_src = BSRC_RS2;
        ctrl.reg_wr    = rd_nz;
        if (func7 == F7_MULDIV) begin
          ctrl.kind    = K_MULDIV;
          ctrl.alu_ctr = ALU_MULDIV;
          ctrl.wb_sel  = WB_MD;
          illegal      = !ENABLE_M;
        end else if (func7 == F7_BASE) begin
          case (func3)
            3'b000:  ctrl.alu_ctr = ALU_ADD;
            3'b001:  ctrl.alu_ctr = ALU_SLL;
            3'b010:  ctrl.alu_ctr = ALU_SLT;
            3'b011:  ctrl.alu_ctr = ALU_SLTU;
            3'b100:  ctrl.alu_ctr = ALU_XOR;
            3'b101:  ctrl.alu_ctr = ALU_SRL;
            3'b110:  ctrl.alu_ctr = ALU_OR;
            default: ctrl.alu_ctr = ALU_AND;
          endcase
        end else if (func7 == F7_ALT && func3 == 3'b000) begin
          ctrl.alu_ctr = ALU_SUB;
        end else if (func7 == F7_ALT && func3 == 3'b101) begin
          ctrl.alu_ctr = ALU_SRA;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_FENCE: illegal = (func3 != 3'b000);
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with mul/div wait,
// data-bus timeout and a sticky trap state left only through reset.
module multicycle_control_unit
  import rv32_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit ENABLE_M    = 1'b0,
  parameter int MEM_TIMEOUT = 16
) (
  input logic                        clk,
  input logic                        rst_n,
  multicycle_control_unit_if.master  bus
);

  localparam int             TMO_W    = $clog2(MEM_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  if (XLEN != 32) begin : g_xlen_check
    $error("multicycle_control_unit: only XLEN = 32 is supported");
  end
  if (MEM_TIMEOUT < 2) begin : g_timeout_check
    $error("multicycle_control_unit: MEM_TIMEOUT must be at least 2");
  end

  state_t            state_q, state_d;
  logic [XLEN-1:0]   ir_q;
  ctrl_t             ctrl_q, dec_ctrl;
  logic              dec_illegal;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              is_jump;

  rv32_decoder #(.ENABLE_M(ENABLE_M)) u_decoder (
    .ir      (ir_q),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  assign is_jump = (ctrl_q.kind == K_JAL) || (ctrl_q.kind == K_JALR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ir_q    <= NOP_INSN;
      ctrl_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      if (bus.ir_we) ir_q <= bus.imem_rdata;
      if (state_q == S_DECODE) ctrl_q <= dec_ctrl;
    end
  end

  always_comb begin
    state_d     = state_q;
    tmo_d       = '0;
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    bus.md_start = 1'b0;
    bus.ir_we    = 1'b0;
    bus.pc_we    = 1'b0;
    bus.pc_sel   = PC_PLUS4;
    bus.wb_sel   = WB_ALU;
    bus.ExtOp    = 3'b000;
    bus.RegWr    = 1'b0;
    bus.ALUASrc  = 1'b0;
    bus.ALUBSrc  = 2'b00;
    bus.ALUCtr   = 5'b00000;
    bus.MemWr    = 1'b0;
    bus.MemOp    = 3'b000;
    bus.trap     = 1'b0;
    bus.state    = state_q;
    // Outputs are forced low while reset is held, not just after the next edge.
    if (rst_n) begin
      if (state_q inside {S_EXEC, S_MEM, S_MDWAIT, S_WB}) begin
        bus.ExtOp   = ctrl_q.ext_op;
        bus.ALUASrc = ctrl_q.alu_a_src;
        bus.ALUBSrc = ctrl_q.alu_b_src;
        bus.ALUCtr  = ctrl_q.alu_ctr;
      end
      case (state_q)
        S_FETCH: begin
          bus.imem_req = 1'b1;
          if (bus.imem_valid) begin
            bus.ir_we = 1'b1;
            state_d   = S_DECODE;
          end
        end
        S_DECODE: state_d = dec_illegal ? S_TRAP : S_EXEC;
        S_EXEC: begin
          case (ctrl_q.kind)
            K_BRANCH: begin
              bus.pc_we  = 1'b1;
              bus.pc_sel = bus.branch_cond ? PC_IMM : PC_PLUS4;
              state_d    = S_FETCH;
            end
            K_JAL: begin
              bus.pc_we  = 1'b1;
              bus.pc_sel = PC_IMM;
              state_d    = S_WB;
            end
            K_JALR: begin
              bus.pc_we  = 1'b1;
              bus.pc_sel = PC_REG;
              state_d    = S_WB;
            end
            K_LOAD, K_STORE: state_d = S_MEM;
            K_MULDIV: begin
              bus.md_start = 1'b1;
              state_d      = S_MDWAIT;
            end
            default: state_d = S_WB;
          endcase
        end
        S_MEM: begin
          bus.dmem_req = 1'b1;
          bus.MemOp    = ctrl_q.mem_op;
          bus.MemWr    = (ctrl_q.kind == K_STORE);
          // A ready arriving on the final allowed cycle still completes the access.
          if (bus.dmem_ready) begin
            if (ctrl_q.kind == K_STORE) begin
              bus.pc_we = 1'b1;
              state_d   = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end else if (tmo_q == TMO_LAST) begin
            state_d = S_TRAP;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        S_MDWAIT: if (bus.md_done) state_d = S_WB;
        S_WB: begin
          bus.RegWr  = ctrl_q.reg_wr;
          bus.wb_sel = ctrl_q.wb_sel;
          bus.MemOp  = ctrl_q.mem_op;
          bus.pc_we  = !is_jump;
          state_d    = S_FETCH;
        end
        S_TRAP:  bus.trap = 1'b1;
        default: state_d = S_TRAP;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Cycle-accurate scoreboard bench for the multicycle control unit (ENABLE_M = 0 and 1).
`timescale 1ns/1ps
module tb_multicycle_control_unit;
  import rv32_ctrl_pkg::*;

  localparam int IMQ = 8'h80, IRW = 8'h40, DMQ = 8'h20, MDS = 8'h10;
  localparam int PCW = 8'h08, RGW = 8'h04, MWR = 8'h02, TRP = 8'h01;
  localparam int X   = -1;

  typedef struct {
    string tag;
    bit    sel;
    int    st;
    int    strb;
    int    psel;
    int    wsel;
    int    mop;
    int    actr;
  } exp_t;

  exp_t        sb_q[$];
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cur_insn;
  bit          sel;
  int          checks = 0;
  int          errors = 0;

  multicycle_control_unit_if bus0 ();
  multicycle_control_unit_if bus1 ();

  multicycle_control_unit #(.XLEN(32), .ENABLE_M(1'b0), .MEM_TIMEOUT(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  multicycle_control_unit #(.XLEN(32), .ENABLE_M(1'b1), .MEM_TIMEOUT(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs to both DUTs and queue what the selected one must show.
  task automatic cyc(input string tag, input logic iv, input logic dr, input logic bc,
                     input logic md, input int st, input int strb, input int psel,
                     input int wsel, input int mop, input int actr);
    exp_t e;
    bus0.imem_valid = iv; bus1.imem_valid = iv;
    bus0.imem_rdata = cur_insn; bus1.imem_rdata = cur_insn;
    bus0.dmem_ready = dr; bus1.dmem_ready = dr;
    bus0.branch_cond = bc; bus1.branch_cond = bc;
    bus0.md_done = md; bus1.md_done = md;
    e.tag = tag; e.sel = sel; e.st = st; e.strb = strb;
    e.psel = psel; e.wsel = wsel; e.mop = mop; e.actr = actr;
    sb_q.push_back(e);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [2:0]  o_st;
    logic [7:0]  o_strb;
    logic [1:0]  o_psel, o_wsel;
    logic [2:0]  o_mop;
    logic [4:0]  o_actr;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.sel) begin
        o_st   = bus1.state;
        o_strb = {bus1.imem_req, bus1.ir_we, bus1.dmem_req, bus1.md_start,
                  bus1.pc_we, bus1.RegWr, bus1.MemWr, bus1.trap};
        o_psel = bus1.pc_sel; o_wsel = bus1.wb_sel; o_mop = bus1.MemOp; o_actr = bus1.ALUCtr;
      end else begin
        o_st   = bus0.state;
        o_strb = {bus0.imem_req, bus0.ir_we, bus0.dmem_req, bus0.md_start,
                  bus0.pc_we, bus0.RegWr, bus0.MemWr, bus0.trap};
        o_psel = bus0.pc_sel; o_wsel = bus0.wb_sel; o_mop = bus0.MemOp; o_actr = bus0.ALUCtr;
      end
      check_val({e.tag, ".state"}, o_st, e.st);
      check_val({e.tag, ".strobes"}, o_strb, e.strb);
      if (e.psel >= 0) check_val({e.tag, ".pc_sel"}, o_psel, e.psel);
      if (e.wsel >= 0) check_val({e.tag, ".wb_sel"}, o_wsel, e.wsel);
      if (e.mop >= 0)  check_val({e.tag, ".MemOp"}, o_mop, e.mop);
      if (e.actr >= 0) check_val({e.tag, ".ALUCtr"}, o_actr, e.actr);
    end
  end

  task automatic fetch_decode(input string tag, input logic [31:0] insn);
    cur_insn = insn;
    cyc(tag, 1, 0, 0, 0, S_FETCH, IMQ | IRW, X, X, X, X);
    cyc(tag, 0, 0, 0, 0, S_DECODE, 0, X, X, X, X);
  endtask

  task automatic alu_insn(input string tag, input logic [31:0] insn, input bit wr, input int actr);
    fetch_decode(tag, insn);
    cyc(tag, 0, 0, 0, 0, S_EXEC, 0, X, X, X, actr);
    cyc(tag, 0, 0, 0, 0, S_WB, PCW | (wr ? RGW : 0), PC_PLUS4, WB_ALU, X, X);
  endtask

  task automatic load_insn(input string tag, input logic [31:0] insn, input int n, input int mop);
    fetch_decode(tag, insn);
    cyc(tag, 0, 0, 0, 0, S_EXEC, 0, X, X, X, X);
    for (int i = 0; i < n; i++)
      cyc(tag, 0, (i == n - 1), 0, 0, S_MEM, DMQ, X, X, mop, X);
    cyc(tag, 0, 0, 0, 0, S_WB, PCW | RGW, PC_PLUS4, WB_MEM, X, X);
  endtask

  task automatic store_insn(input string tag, input logic [31:0] insn, input int n);
    fetch_decode(tag, insn);
    cyc(tag, 0, 0, 0, 0, S_EXEC, 0, X, X, X, X);
    for (int i = 0; i < n - 1; i++)
      cyc(tag, 0, 0, 0, 0, S_MEM, DMQ | MWR, X, X, MEM_W, X);
    cyc(tag, 0, 1, 0, 0, S_MEM, DMQ | MWR | PCW, PC_PLUS4, X, MEM_W, X);
  endtask

  task automatic branch_insn(input string tag, input logic bc);
    fetch_decode(tag, 32'h0020_8463);
    cyc(tag, 0, 0, bc, 0, S_EXEC, PCW, bc ? PC_IMM : PC_PLUS4, X, X, ALU_BEQ);
  endtask

  task automatic jump_insn(input string tag, input logic [31:0] insn, input int psel);
    fetch_decode(tag, insn);
    cyc(tag, 0, 0, 0, 0, S_EXEC, PCW, psel, X, X, X);
    cyc(tag, 0, 0, 0, 0, S_WB, RGW, X, WB_PC4, X, X);
  endtask

  task automatic illegal_insn(input string tag, input logic [31:0] insn);
    fetch_decode(tag, insn);
    cyc(tag, 0, 0, 0, 0, S_TRAP, TRP, X, X, X, X);
    cyc(tag, 1, 1, 0, 1, S_TRAP, TRP, X, X, X, X);
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    cyc(tag, 1, 1, 1, 1, S_FETCH, 0, X, X, X, X);
    rst_n = 1'b1;
  endtask

  initial begin
    sel = 1'b0;
    cur_insn = NOP_INSN;
    @(posedge clk); #1;
    cyc("reset", 1, 1, 1, 1, S_FETCH, 0, X, X, X, X);
    cyc("reset", 1, 0, 0, 0, S_FETCH, 0, X, X, X, X);
    rst_n = 1'b1;
    cyc("fetch_wait", 0, 0, 0, 0, S_FETCH, IMQ, X, X, X, X);

    alu_insn("add", 32'h0020_81B3, 1'b1, ALU_ADD);
    alu_insn("sub", 32'h4020_81B3, 1'b1, ALU_SUB);
    alu_insn("addi", 32'h0050_0093, 1'b1, ALU_ADDI);
    alu_insn("lui", 32'h1234_52B7, 1'b1, ALU_LUI);
    alu_insn("add_x0", 32'h0020_8033, 1'b0, ALU_ADD);
    load_insn("lw", 32'h0080_A283, 3, MEM_W);
    load_insn("lbu", 32'h0000_C283, 1, MEM_BU);
    store_insn("sw_fast", 32'h0020_A223, 1);
    store_insn("sw_edge", 32'h0020_A223, 16);
    branch_insn("beq_t", 1'b1);
    branch_insn("beq_nt", 1'b0);
    jump_insn("jal", 32'h0080_00EF, PC_IMM);
    jump_insn("jalr", 32'h0001_00E7, PC_REG);

    fetch_decode("sw_tmo", 32'h0020_A223);
    cyc("sw_tmo", 0, 0, 0, 0, S_EXEC, 0, X, X, X, X);
    for (int i = 0; i < 16; i++)
      cyc("sw_tmo", 0, 0, 0, 0, S_MEM, DMQ | MWR, X, X, MEM_W, X);
    cyc("sw_tmo", 0, 0, 0, 0, S_TRAP, TRP, X, X, X, X);
    cyc("sw_tmo", 0, 1, 0, 0, S_TRAP, TRP, X, X, X, X);
    apply_reset("rst_after_tmo");

    illegal_insn("ill_ffff", 32'hFFFF_FFFF);
    apply_reset("rst_after_ill");
    illegal_insn("ill_sll_alt", 32'h4020_9133);
    apply_reset("rst_after_ill2");
    illegal_insn("mul_m0", 32'h0220_81B3);
    apply_reset("rst_after_mul0");

    sel = 1'b1;
    fetch_decode("mul_m1", 32'h0220_81B3);
    cyc("mul_m1", 0, 0, 0, 0, S_EXEC, MDS, X, X, X, ALU_MULDIV);
    for (int i = 0; i < 5; i++)
      cyc("mul_m1", 0, 0, 0, (i == 4), S_MDWAIT, 0, X, X, X, X);
    cyc("mul_m1", 0, 0, 0, 0, S_WB, PCW | RGW, PC_PLUS4, WB_MD, X, X);
    cyc("mul_m1", 0, 0, 0, 0, S_FETCH, IMQ, X, X, X, X);
    apply_reset("rst_after_mul1");
    sel = 1'b0;

    fetch_decode("lw_abort", 32'h0080_A283);
    cyc("lw_abort", 0, 0, 0, 0, S_EXEC, 0, X, X, X, X);
    cyc("lw_abort", 0, 0, 0, 0, S_MEM, DMQ, X, X, MEM_W, X);
    cyc("lw_abort", 0, 0, 0, 0, S_MEM, DMQ, X, X, MEM_W, X);
    apply_reset("lw_abort_rst");
    cyc("lw_abort_post", 0, 1, 0, 0, S_FETCH, IMQ, X, X, X, X);
    cyc("lw_abort_post", 0, 1, 0, 0, S_FETCH, IMQ, X, X, X, X);
    alu_insn("add_after", 32'h0020_81B3, 1'b1, ALU_ADD);

    check_val("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
